joypad_serializer: RTL and testbench
====================================

# joypad_serializer

Parametrised multi-port joypad serial bridge between the controller front-ends (`controller_snes`, USB/BL616 HID) and the console core's joypad strobe/clock/data interface. It replaces the fixed two-port, 8-bit inline shift logic and per-button autofire instances in the top level. The block adds the following:
- generic port count and button width;
- one shared autofire divider with per-port enable;
- glitch-free port swap;
- per-port read-complete pulses for input-latency instrumentation.

## Interface
Parameters:
- `NUM_PORTS`, 2: number of joypad ports.
- `BTN_W`, 12: button vector width per port (layout R L X A RT LT DN UP START SELECT Y B, MSB first).
- `SHIFT_W`, 8: bits loaded into each port shift register, from button bits [SHIFT_W-1:0].
- `AF_A_SRC`, 8: button index whose autofire is ORed into shift bit 0.
- `AF_B_SRC`, 9: button index whose autofire is ORed into shift bit 1.
- `AF_HALF`, 357_950: clk cycles per autofire phase. This is 1/60 s at 21.477 MHz.

Ports:
- `clk`, in, 1: core clock. All inputs are synchronous to it.
- `reset`, in, 1: synchronous, active-high.
- `joy_btns`, in, NUM_PORTS*BTN_W: button state. Port p occupies [p*BTN_W +: BTN_W]; 1 = pressed.
- `af_en`, in, NUM_PORTS: per-port autofire enable.
- `joy_swap`, in, 1: exchange the port 0 and port 1 sources. Ignored when NUM_PORTS < 2.
- `joypad_strobe`, in, 1: latch strobe shared by all ports. Level-sensitive.
- `joypad_clock`, in, NUM_PORTS: per-port shift clock. Shifts on the falling edge.
- `joypad_data`, out, NUM_PORTS: serial data, bit 0 of each shift register.
- `read_done`, out, NUM_PORTS: one-cycle pulse when the SHIFT_W-th bit has been shifted out.

## Operation
- Source select: `src[p]` = `joy_btns` slice p. When the registered swap flag is 1, ports 0 and 1 exchange sources.
  - The swap flag samples `joy_swap` only on the rising edge of `joypad_strobe`, so it never changes mid-read.
- Autofire:
  - One free-running counter, 0..AF_HALF-1. `phase` toggles when the counter wraps.
  - `auto_a[p]` = `src[p][AF_A_SRC]` & `phase` & `af_en[p]`. `auto_b[p]` is formed the same way from AF_B_SRC.
- Load word: `src[p][SHIFT_W-1:2]`, `src[p][1]|auto_b[p]`, `src[p][0]|auto_a[p]`.
- Per port, priority highest first:
  1. `reset`: shift register set to all ones, bit count 0, last clock 0, `read_done` 0.
  2. `joypad_strobe`=1: parallel load every cycle, bit count 0. A simultaneous clock edge is ignored.
  3. Falling edge (`last_clk`=1, `joypad_clock[p]`=0): shift right with 1 inserted at the MSB. Bit count increments and saturates at SHIFT_W.
- After SHIFT_W shifts `joypad_data` reads 1 indefinitely. This is the open-bus fill.
- `read_done[p]` pulses on the cycle the bit count moves from SHIFT_W-1 to SHIFT_W.
  - It does not pulse again until a new load.
- Ports are fully independent apart from the shared strobe, swap flag and autofire divider.

## Timing
- Falling edge visible at cycle n: the shift register updates at the end of n. New `joypad_data` is valid from cycle n+1. `read_done` asserts in cycle n+1.
- Strobe load: `joypad_data` reflects `src` bit 0 one cycle after each strobe-high cycle. It tracks live button changes while strobe is held.
- Swap flag: the new value applies to the load performed in the same cycle as the strobe rising edge.
- Autofire: `phase` period is 2*AF_HALF cycles.
- Reset values:
  - `joypad_data` = all 1;
  - `read_done` = 0;
  - `phase` = 0, counter = 0;
  - swap flag = 0.
- `last_clk` reset to 0 prevents a spurious edge immediately after reset.
- Reset asserted mid-read: the state returns to the reset values next cycle; the partial read is abandoned.

## Configuration
- `JOYPAD_AUTOFIRE_EN` defined: the divider and autofire OR terms are built as above.
- Undefined:
  - no divider logic;
  - `auto_a`/`auto_b` tied to 0;
  - `af_en` unused;
  - load word = `src[p][SHIFT_W-1:0]` unmodified.

## Structure
- `configPackage` holds the button index constants and the default AF_HALF.
  - Button constants: BTN_B=0, BTN_Y=1, BTN_SELECT=2, BTN_START=3, BTN_UP=4, BTN_DN=5, BTN_LT=6, BTN_RT=7, BTN_A=8, BTN_X=9, BTN_L=10, BTN_R=11.
- Sub-module `joypad_shift_port` is instantiated NUM_PORTS times via generate. It contains the shift register, edge detect, bit counter and `read_done`.
- The top of the block owns the swap flag, source muxing and the shared autofire divider.

## Test plan
- **Basic read:** port 0 buttons = 12'h0A5, strobe 1 cycle high, then 8 clock falling edges. Required: `joypad_data` sequence 1,0,1,0,0,1,0,1; then 1 forever; `read_done[0]` pulses once, one cycle after the 8th edge.
- **Swap:** port 0 = 12'h001, port 1 = 12'h002. Raise `joy_swap` mid-read: no change to the current read. After the next strobe, port 0 first bit = 0 and port 1 first bit = 1.
- **Autofire** (AF_HALF=4 for sim, macro defined): `af_en`=01, bit 8 held on port 0. Repeated strobes show bit 0 alternating every 4 cycles. Port 1 with bit 8 held shows bit 0 = 0 constantly.
- **Macro undefined:** same stimulus as the autofire test gives bit 0 = 0 always.
- **Collisions:** strobe high while a clock falls → loaded value wins, bit count 0. 12 edges without strobe → only one `read_done` pulse.
- **Reset mid-read:** reset after 3 shifts → `joypad_data`=1 and `read_done`=0 next cycle. A clock held low across reset release produces no shift.

Source files
------------

// File: rtl/joypad_serializer_pkg.sv
// Shared joypad constants: button bit positions (R L X A RT LT DN UP START SELECT Y B, MSB first)
// and the default autofire half-period.
package configPackage;

  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DN     = 5;
  localparam int BTN_LT     = 6;
  localparam int BTN_RT     = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  // 1/60 s at 21.477 MHz
  localparam int AF_HALF_DEFAULT = 357_950;

endpackage

// File: rtl/joypad_serializer_shift_port.sv
// One joypad port: parallel load on strobe, falling-edge shift with open-bus 1 fill,
// saturating bit counter and a single read-complete pulse per load.
module joypad_shift_port
  import configPackage::*;
#(
  parameter int SHIFT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               strobe,
  input  logic               joy_clock,
  input  logic [SHIFT_W-1:0] load_word,
  output logic               data,
  output logic               read_done
);

  localparam int CNT_W = $clog2(SHIFT_W + 1);

  logic [SHIFT_W-1:0] shift_q;
  logic [CNT_W-1:0]   bit_cnt;
  logic               last_clk;
  logic               done_q;
  logic               fall;

  assign fall = last_clk & ~joy_clock;

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q  <= '1;
      bit_cnt  <= '0;
      last_clk <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      last_clk <= joy_clock;
      done_q   <= 1'b0;
      if (strobe) begin
        // a clock edge coinciding with the strobe is dropped on purpose
        shift_q <= load_word;
        bit_cnt <= '0;
      end else if (fall) begin
        shift_q <= SHIFT_W'({1'b1, shift_q} >> 1);
        if (bit_cnt != CNT_W'(SHIFT_W))
          bit_cnt <= bit_cnt + 1'b1;
        done_q <= (bit_cnt == CNT_W'(SHIFT_W - 1));
      end
    end
  end

  assign data      = shift_q[0];
  assign read_done = done_q;

endmodule

// File: rtl/joypad_serializer.sv
// Multi-port joypad serial bridge: strobe-latched port swap, shared autofire divider and
// per-port shift registers. Autofire is built only when JOYPAD_AUTOFIRE_EN is defined.
module joypad_serializer
  import configPackage::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int BTN_W     = 12,
  parameter int SHIFT_W   = 8,
  parameter int AF_A_SRC  = BTN_A,
  parameter int AF_B_SRC  = BTN_X,
  parameter int AF_HALF   = AF_HALF_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_PORTS*BTN_W-1:0] joy_btns,
  input  logic [NUM_PORTS-1:0]       af_en,
  input  logic                       joy_swap,
  input  logic                       joypad_strobe,
  input  logic [NUM_PORTS-1:0]       joypad_clock,
  output logic [NUM_PORTS-1:0]       joypad_data,
  output logic [NUM_PORTS-1:0]       read_done
);

  logic strobe_q;
  logic swap_q;
  logic swap_eff;

  // The swap choice is taken at the strobe rising edge and used by that same load.
  assign swap_eff = (joypad_strobe & ~strobe_q) ? joy_swap : swap_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_q <= 1'b0;
      swap_q   <= 1'b0;
    end else begin
      strobe_q <= joypad_strobe;
      swap_q   <= swap_eff;
    end
  end

`ifdef JOYPAD_AUTOFIRE_EN
  localparam int AF_CW = (AF_HALF > 1) ? $clog2(AF_HALF) : 1;

  logic [AF_CW-1:0] af_cnt;
  logic             phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      af_cnt <= '0;
      phase  <= 1'b0;
    end else if (af_cnt == AF_CW'(AF_HALF - 1)) begin
      af_cnt <= '0;
      phase  <= ~phase;
    end else begin
      af_cnt <= af_cnt + 1'b1;
    end
  end
`else
  logic unused_af_en;
  assign unused_af_en = ^af_en;
`endif

  logic [BTN_W-1:0]   src       [NUM_PORTS];
  logic [SHIFT_W-1:0] load_word [NUM_PORTS];
  logic [NUM_PORTS-1:0] unused_src;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    if (NUM_PORTS >= 2 && p < 2) begin : g_swap
      assign src[p] = swap_eff ? joy_btns[(1-p)*BTN_W +: BTN_W] : joy_btns[p*BTN_W +: BTN_W];
    end else begin : g_direct
      assign src[p] = joy_btns[p*BTN_W +: BTN_W];
    end

    assign unused_src[p] = ^src[p];

`ifdef JOYPAD_AUTOFIRE_EN
    logic auto_a;
    logic auto_b;
    assign auto_a = src[p][AF_A_SRC] & phase & af_en[p];
    assign auto_b = src[p][AF_B_SRC] & phase & af_en[p];
    assign load_word[p] = src[p][SHIFT_W-1:0] | {{(SHIFT_W-2){1'b0}}, auto_b, auto_a};
`else
    assign load_word[p] = src[p][SHIFT_W-1:0];
`endif

    joypad_shift_port #(
      .SHIFT_W (SHIFT_W)
    ) u_port (
      .clk       (clk),
      .reset     (reset),
      .strobe    (joypad_strobe),
      .joy_clock (joypad_clock[p]),
      .load_word (load_word[p]),
      .data      (joypad_data[p]),
      .read_done (read_done[p])
    );
  end

endmodule

// File: tb/tb_joypad_serializer.sv
// Directed bench for joypad_serializer (2 ports, AF_HALF=4); autofire expectations follow
// whether JOYPAD_AUTOFIRE_EN is defined for the build.
module tb_joypad_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] joy_btns;
  logic [1:0]  af_en;
  logic        joy_swap;
  logic        joypad_strobe;
  logic [1:0]  joypad_clock;
  logic [1:0]  joypad_data;
  logic [1:0]  read_done;

  int n_cmp = 0;
  int n_err = 0;

  joypad_serializer #(
    .NUM_PORTS (2),
    .BTN_W     (12),
    .SHIFT_W   (8),
    .AF_A_SRC  (8),
    .AF_B_SRC  (9),
    .AF_HALF   (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .joy_btns      (joy_btns),
    .af_en         (af_en),
    .joy_swap      (joy_swap),
    .joypad_strobe (joypad_strobe),
    .joypad_clock  (joypad_clock),
    .joypad_data   (joypad_data),
    .read_done     (read_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // falling edge on port 0 followed by a return to high
  task automatic edge0();
    joypad_clock[0] = 1'b0;
    tick();
    joypad_clock[0] = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] pat;
    logic       exp0;
    int         pulses;
    pat = 8'hA5;

    reset         = 1'b1;
    joy_btns      = '0;
    af_en         = 2'b00;
    joy_swap      = 1'b0;
    joypad_strobe = 1'b0;
    joypad_clock  = 2'b11;
    repeat (3) tick();
    check("reset_data", joypad_data, 2'b11);
    check("reset_done", read_done, 2'b00);
    reset = 1'b0;
    tick();
    check("idle_data", joypad_data, 2'b11);

    // basic read of 0x0A5 on port 0
    joy_btns      = {12'h000, 12'h0A5};
    joypad_strobe = 1'b1;
    tick();
    joypad_strobe = 1'b0;
    check("basic_bit0", joypad_data[0], 1'b1);
    check("basic_p1_bit0", joypad_data[1], 1'b0);
    for (int i = 1; i <= 10; i++) begin
      joypad_clock[0] = 1'b0;
      tick();
      check($sformatf("basic_data_%0d", i), joypad_data[0], (i < 8) ? pat[i] : 1'b1);
      check($sformatf("basic_done_%0d", i), read_done[0], (i == 8));
      joypad_clock[0] = 1'b1;
      tick();
      check($sformatf("basic_done_low_%0d", i), read_done[0], 1'b0);
    end

    // swap: flag only follows joy_swap at a strobe rising edge
    joy_btns      = {12'h002, 12'h001};
    joypad_strobe = 1'b1;
    tick();
    joypad_strobe = 1'b0;
    check("swap_load_plain", joypad_data, 2'b01);
    joypad_clock = 2'b00;
    tick();
    check("swap_shift1", joypad_data, 2'b10);
    joypad_clock = 2'b11;
    joy_swap     = 1'b1;
    tick();
    check("swap_midread_hold", joypad_data, 2'b10);
    joypad_clock = 2'b00;
    tick();
    check("swap_shift2", joypad_data, 2'b00);
    joypad_clock  = 2'b11;
    tick();
    joypad_strobe = 1'b1;
    tick();
    check("swap_load_swapped", joypad_data, 2'b10);
    joy_swap = 1'b0;
    tick();
    check("swap_held_strobe", joypad_data, 2'b10);
    joypad_strobe = 1'b0;
    tick();
    check("swap_after_strobe", joypad_data, 2'b10);
    joypad_strobe = 1'b1;
    tick();
    check("swap_cleared", joypad_data, 2'b01);
    joypad_strobe = 1'b0;
    tick();

    // autofire: bit 8 held on both ports, enabled on port 0 only, strobe held
    reset         = 1'b1;
    joy_btns      = {12'h100, 12'h100};
    af_en         = 2'b01;
    joypad_strobe = 1'b1;
    tick();
    reset = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      tick();
`ifdef JOYPAD_AUTOFIRE_EN
      exp0 = (((j - 1) / 4) % 2) == 1;
`else
      exp0 = 1'b0;
`endif
      check($sformatf("af_cycle_%0d", j), joypad_data, {1'b0, exp0});
    end
    joypad_strobe = 1'b0;
    af_en         = 2'b00;
    tick();

    // strobe colliding with a falling edge: load wins and the count restarts
    joy_btns      = {12'h000, 12'h0A5};
    joypad_strobe = 1'b1;
    tick();
    joypad_strobe = 1'b0;
    repeat (3) edge0();
    check("coll_pre_bit3", joypad_data[0], pat[3]);
    joypad_clock[0] = 1'b0;
    joypad_strobe   = 1'b1;
    tick();
    check("coll_loaded", joypad_data[0], 1'b1);
    check("coll_no_done", read_done[0], 1'b0);
    joypad_strobe   = 1'b0;
    joypad_clock[0] = 1'b1;
    tick();
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      joypad_clock[0] = 1'b0;
      tick();
      if (read_done[0]) pulses++;
      check($sformatf("coll_data_%0d", i), joypad_data[0], (i < 8) ? pat[i] : 1'b1);
      if (i == 8) check("coll_done_at_8", read_done[0], 1'b1);
      joypad_clock[0] = 1'b1;
      tick();
      if (read_done[0]) pulses++;
    end
    check("coll_pulse_count", pulses, 1);

    // reset mid-read with the clock held low across release
    joypad_strobe = 1'b1;
    tick();
    joypad_strobe = 1'b0;
    repeat (3) edge0();
    check("rst_pre_bit3", joypad_data[0], pat[3]);
    joypad_clock[0] = 1'b0;
    reset           = 1'b1;
    tick();
    check("rst_mid_data", joypad_data, 2'b11);
    check("rst_mid_done", read_done, 2'b00);
    reset = 1'b0;
    tick();
    tick();
    check("rst_release_data", joypad_data[0], 1'b1);
    check("rst_release_done", read_done[0], 1'b0);
    joypad_clock[0] = 1'b1;
    tick();
    for (int i = 1; i <= 8; i++) begin
      joypad_clock[0] = 1'b0;
      tick();
      check($sformatf("rst_done_%0d", i), read_done[0], (i == 8));
      check($sformatf("rst_fill_%0d", i), joypad_data[0], 1'b1);
      joypad_clock[0] = 1'b1;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
